// File: rtl/key_expansion.sv
// AES-128 key schedule: presents the cipher key and ROUNDS expanded round keys,
// one per accepted rk_valid/rk_ready handshake, then pulses done.

// AES S-box evaluated as the GF(2^8) multiplicative inverse followed by the affine map.
module sbox_LUT (
   input  logic [7:0] addr,
   output logic [7:0] data
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is a^-1 in GF(2^8), and conveniently maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign data = affine(gf_inv(addr));

endmodule

module key_expansion #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         rk_valid,
   output logic [3:0]   rk_index,
   output logic [127:0] round_key,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   state_t         state_r;
   state_t         state_next_s;
   logic [127:0]   key_r;
   logic [127:0]   key_next_s;
   logic [3:0]     cnt_r;
   logic [3:0]     cnt_next_s;
   logic           valid_r;
   logic           busy_r;
   logic           done_r;

   logic [31:0]    rot_s;
   logic [31:0]    sub_s;
   logic [31:0]    t_s;
   logic [31:0]    w0_s;
   logic [31:0]    w1_s;
   logic [31:0]    w2_s;
   logic [31:0]    w3_s;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // RotWord on w3: byte 0 (MSB) moves to the least significant byte
   assign rot_s = {key_r[23:0], key_r[31:24]};

   sbox_LUT u_sbox0 (.addr(rot_s[31:24]), .data(sub_s[31:24]));
   sbox_LUT u_sbox1 (.addr(rot_s[23:16]), .data(sub_s[23:16]));
   sbox_LUT u_sbox2 (.addr(rot_s[15:8]),  .data(sub_s[15:8]));
   sbox_LUT u_sbox3 (.addr(rot_s[7:0]),   .data(sub_s[7:0]));

   assign t_s  = sub_s ^ {rcon(cnt_r + 4'd1), 24'h000000};
   assign w0_s = key_r[127:96] ^ t_s;
   assign w1_s = key_r[95:64]  ^ w0_s;
   assign w2_s = key_r[63:32]  ^ w1_s;
   assign w3_s = key_r[31:0]   ^ w2_s;

   // Next-state, key and round counter selection
   always_comb begin
      state_next_s = state_r;
      key_next_s   = key_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = EMIT;
               key_next_s   = key_in;
               cnt_next_s   = 4'd0;
            end else begin
               state_next_s = IDLE;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (cnt_r == LAST_ROUND) begin
                  state_next_s = FINISH;
               end else begin
                  key_next_s = {w0_s, w1_s, w2_s, w3_s};
                  cnt_next_s = cnt_r + 4'd1;
               end
            end else begin
               state_next_s = EMIT;
            end
         end
         FINISH:  state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State and output registers; handshake flags are decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         key_r   <= 128'h0;
         cnt_r   <= 4'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         key_r   <= key_next_s;
         cnt_r   <= cnt_next_s;
         valid_r <= (state_next_s == EMIT);
         busy_r  <= (state_next_s == EMIT);
         done_r  <= (state_next_s == FINISH);
      end
   end

   assign rk_valid  = valid_r;
   assign rk_index  = cnt_r;
   assign round_key = key_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 key schedule model plus handshake
// model, checked every cycle, with directed corner cases and a ROUNDS=1 instance.
module tb_key_expansion;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = 128'h0;
   logic         rk_ready = 1'b0;
   logic         rk_valid;
   logic [3:0]   rk_index;
   logic [127:0] round_key;
   logic         busy;
   logic         done;

   logic         start1 = 1'b0;
   logic         ready1 = 1'b0;
   logic         valid1;
   logic [3:0]   idx1;
   logic [127:0] rk1;
   logic         busy1;
   logic         done1;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   logic [7:0] sb [0:255];

   always #5 clk = ~clk;

   key_expansion #(.ROUNDS(10)) dut (
      .clk(clk), .reset(reset), .start(start), .key_in(key_in), .rk_ready(rk_ready),
      .rk_valid(rk_valid), .rk_index(rk_index), .round_key(round_key), .busy(busy), .done(done)
   );

   key_expansion #(.ROUNDS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .key_in(key_in), .rk_ready(ready1),
      .rk_valid(valid1), .rk_index(idx1), .round_key(rk1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [7:0] xt(input logic [7:0] p);
      return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table from exp/log tables with generator 3, then the affine map
   task automatic build_sbox();
      logic [7:0] ex [0:254];
      int lg [0:255];
      logic [7:0] p;
      logic [7:0] inv;
      p = 8'h01;
      for (int i = 0; i < 255; i++) begin
         ex[i] = p;
         lg[p] = i;
         p = p ^ xt(p);
      end
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   // FIPS-197 word-oriented key expansion, returning round key r
   function automatic logic [127:0] fips_rk(input logic [127:0] k, input int r);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            rc = 8'h01;
            for (int j = 1; j < i / 4; j++) rc = xt(rc);
            t = t ^ {rc, 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Behavioural model of the handshake: 0 idle, 1 emitting, 2 finishing
   int           m_state = 0;
   int           m_idx = 0;
   logic [127:0] m_key = 128'h0;
   logic [127:0] m_rk = 128'h0;

   always @(posedge clk) begin
      if (reset) begin
         m_state <= 0;
         m_idx   <= 0;
         m_rk    <= 128'h0;
      end else begin
         case (m_state)
            0: if (start) begin
                  m_state <= 1; m_idx <= 0; m_key <= key_in; m_rk <= key_in;
               end
            1: if (rk_ready) begin
                  if (m_idx == 10) m_state <= 2;
                  else begin
                     m_idx <= m_idx + 1;
                     m_rk  <= fips_rk(m_key, m_idx + 1);
                  end
               end
            default: m_state <= 0;
         endcase
      end
   end

   // Compare every cycle, on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rk_valid", 128'(rk_valid), 128'(m_state == 1));
         chk("busy", 128'(busy), 128'(m_state == 1));
         chk("done", 128'(done), 128'(m_state == 2));
         chk("round_key", round_key, m_rk);
         if (m_state == 1) chk("rk_index", 128'(rk_index), 128'(m_idx));
      end
   end

   task automatic pulse_start(input logic [127:0] k);
      key_in = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idx(input int idx);
      bit found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         if (rk_valid && rk_index == 4'(idx)) found = 1'b1;
         else @(negedge clk);
      end
      chk("wait_idx", 128'(found), 128'(1));
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 200) begin
         rk_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : rk_ready;
         @(negedge clk);
         cycles++;
      end
      chk("wait_done", 128'(done), 128'(1));
      @(negedge clk);
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      int cyc;
      logic [127:0] k1;
      logic [127:0] k2;
      logic [127:0] snap;

      build_sbox();
      chk("pin_sbox00", 128'(sb[0]), 128'h63);
      chk("pin_sbox53", 128'(sb[8'h53]), 128'hed);
      chk("pin_fips1", fips_rk(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
      chk("pin_fips10", fips_rk(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("pin_zero1", fips_rk(128'h0, 1), 128'h62636363626363636263636362636363);
      chk("pin_zero10", fips_rk(128'h0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_index", 128'(rk_index), 128'(0));
      chk("rst_key", round_key, 128'h0);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk_en = 1'b1;
      reset = 1'b0;
      @(negedge clk);

      // FIPS-197 vector at full throughput, done latency
      rk_ready = 1'b1;
      pulse_start(FIPS_KEY);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_latency", 128'(cyc), 128'(12));
      @(negedge clk);
      chk("retain_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // All-zero key with random backpressure
      pulse_start(128'h0);
      wait_done(cyc);

      // Three-cycle stall at index 4
      rk_ready = 1'b1;
      k1 = {$urandom, $urandom, $urandom, $urandom};
      pulse_start(k1);
      wait_idx(4);
      rk_ready = 1'b0;
      snap = round_key;
      repeat (3) begin
         @(negedge clk);
         chk("stall_key", round_key, snap);
         chk("stall_idx", 128'(rk_index), 128'(4));
      end
      rk_ready = 1'b1;
      wait_done(cyc);

      // start with another key mid-expansion must be ignored
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      pulse_start(k1);
      wait_idx(5);
      pulse_start(k2);
      wait_done(cyc);
      chk("ignored_start", round_key, fips_rk(k1, 10));

      // Reset at index 6 aborts; next start begins again from the new key
      rk_ready = 1'b1;
      pulse_start(k1);
      wait_idx(6);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_valid", 128'(rk_valid), 128'(0));
      chk("abort_key", round_key, 128'h0);
      chk("abort_busy", 128'(busy), 128'(0));
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 128'(done), 128'(0));
      end
      pulse_start(k2);
      chk("restart_idx0", round_key, k2);
      wait_done(cyc);

      // Random keys with random backpressure
      for (int n = 0; n < 6; n++) begin
         rk_ready = 1'b0;
         pulse_start({$urandom, $urandom, $urandom, $urandom});
         cyc = 0;
         while (!done && cyc < 200) begin
            rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
         end
         chk("rand_done", 128'(done), 128'(1));
         @(negedge clk);
      end

      // ROUNDS=1 instance: exactly two keys then done
      k1 = {$urandom, $urandom, $urandom, $urandom};
      ready1 = 1'b1;
      key_in = k1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("r1_v0", 128'(valid1), 128'(1));
      chk("r1_i0", 128'(idx1), 128'(0));
      chk("r1_k0", rk1, k1);
      @(negedge clk);
      chk("r1_v1", 128'(valid1), 128'(1));
      chk("r1_i1", 128'(idx1), 128'(1));
      chk("r1_k1", rk1, fips_rk(k1, 1));
      @(negedge clk);
      chk("r1_vend", 128'(valid1), 128'(0));
      chk("r1_done", 128'(done1), 128'(1));
      chk("r1_busy", 128'(busy1), 128'(0));
      @(negedge clk);
      chk("r1_done_pulse", 128'(done1), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
